uart_rx_fifo: RTL and testbench

Receive-side byte buffer placed directly downstream of the UART receiver. It drains each completed byte from the receiver the same cycle the byte is offered, so the receiver is immediately free for the next frame. Bytes are held in a small circular FIFO that the CPU/peripheral bus reads at its own pace. The block also reports fill level, a sticky overflow flag and an almost-full hold-off signal.

---
 rtl/uart_rx_fifo.sv | 119 +++++++++++
 tb/tb_uart_rx_fifo.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive-side byte FIFO between the UART receiver and the bus
//
// This FIFO takes every byte the UART receiver offers in the same cycle, so the
// receiver is free for its next frame at once. The bus reads the bytes back
// through a show-ahead head port.
//
// Ports:
//   clk, resetn   clock; synchronous active-low reset
//   rx_valid      receiver has a byte on rx_data, held until rx_read
//   rx_data       received byte
//   rx_read       combinational consume strobe back to the receiver
//   rd_en         bus pop request (ignored while empty)
//   rd_data       head-of-FIFO byte, 0 while empty
//   rd_valid      FIFO not empty
//   level         entry count, 0..DEPTH
//   overflow      sticky: a received byte was discarded
//   clr_overflow  clears overflow (a simultaneous drop wins)
//   flush         synchronous empty; also holds off the receiver
//   rx_hold       registered almost-full (level >= AFULL_LEVEL)

module uart_rx_fifo #(
  parameter int DEPTH       = 8,
  parameter int DATA_BITS   = 8,
  parameter int AFULL_LEVEL = DEPTH - 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   rx_valid,
  input  logic [DATA_BITS-1:0]   rx_data,
  output logic                   rx_read,
  input  logic                   rd_en,
  output logic [DATA_BITS-1:0]   rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   clr_overflow,
  input  logic                   flush,
  output logic                   rx_hold
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_L = LW'(AFULL_LEVEL);

  logic [DATA_BITS-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          rx_hold_q, rx_hold_d;

  logic push, pop, drop;

  assign rd_valid = (level_q != '0);
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign level    = level_q;
  assign overflow = overflow_q;
  assign rx_hold  = rx_hold_q;

  always_comb begin
    // The receiver is never stalled by fill level, only by flush. rd_en does
    // not reach rx_read.
    rx_read = rx_valid & ~flush;
    pop     = rd_en & rd_valid & ~flush;
    // When the FIFO is full, a pop in the same cycle frees the slot for this byte.
    push    = rx_read & ((level_q != DEPTH_L) | pop);
    drop    = rx_read & ~push;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end

    // A drop in the same cycle as clr_overflow keeps the flag set.
    if (drop)              overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;
    else                   overflow_d = overflow_q;

    // rx_hold is computed from next level so it moves on the same edge as level.
    rx_hold_d = (level_d >= AFULL_L);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      rx_hold_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      rx_hold_q  <= rx_hold_d;
    end
  end

  // The storage array is not reset.
  always_ff @(posedge clk) begin
    if (resetn && push) mem_q[wr_ptr_q] <= rx_data;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo against a queue model

module tb_uart_rx_fifo;

  localparam int DEPTH = 8;
  localparam int AFULL = DEPTH - 2;

  logic       clk = 1'b0;
  logic       resetn;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_read;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [3:0] level;
  logic       overflow;
  logic       clr_overflow;
  logic       flush;
  logic       rx_hold;

  uart_rx_fifo #(.DEPTH(DEPTH), .DATA_BITS(8), .AFULL_LEVEL(AFULL)) dut (
    .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_read(rx_read), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .level(level), .overflow(overflow), .clr_overflow(clr_overflow),
    .flush(flush), .rx_hold(rx_hold)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_q[$];
  logic       m_ovf  = 1'b0;
  logic       m_hold = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_head();
    logic [7:0] h;
    h = 8'h00;
    if (m_q.size() != 0) h = m_q[0];
    return h;
  endfunction

  // One clock cycle. At the start it checks the registered outputs against the
  // model. It then drives the inputs, checks rx_read, and advances the model on
  // the clock edge. It returns 1 ns after that edge.
  task automatic step(input bit rstn, input bit rxv, input logic [7:0] rxd,
                      input bit rde, input bit clr, input bit fl, output bit rr);
    bit popped, pushed, dropped;
    @(negedge clk);
    chk("level",    32'(level),    32'(m_q.size()));
    chk("rd_valid", 32'(rd_valid), 32'(m_q.size() != 0));
    chk("rd_data",  32'(rd_data),  32'(m_head()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("rx_hold",  32'(rx_hold),  32'(m_hold));
    resetn = rstn; rx_valid = rxv; rx_data = rxd;
    rd_en = rde; clr_overflow = clr; flush = fl;
    #1;
    rr = rx_read;
    chk("rx_read", 32'(rx_read), 32'(rxv && !fl));
    @(posedge clk);
    if (!rstn) begin
      m_q.delete();
      m_ovf  = 1'b0;
      m_hold = 1'b0;
    end else begin
      if (fl) begin
        m_q.delete();
        dropped = 1'b0;
      end else begin
        popped  = rde && (m_q.size() != 0);
        pushed  = rxv && (m_q.size() < DEPTH || popped);
        dropped = rxv && !pushed;
        if (popped) void'(m_q.pop_front());
        if (pushed) m_q.push_back(rxd);
      end
      if (dropped)  m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      m_hold = (m_q.size() >= AFULL);
    end
    #1;
  endtask

  // The receiver holds its byte until rx_read is seen, for at most 20 cycles.
  task automatic offer(input logic [7:0] b, input bit rde);
    bit rr;
    int n;
    rr = 1'b0;
    n  = 0;
    while (!rr && n < 20) begin
      step(1, 1, b, rde, 0, 0, rr);
      n++;
    end
    if (!rr) chk("offer_timeout", 0, 1);
  endtask

  task automatic idle(input bit rde);
    bit rr;
    step(1, 0, 8'h00, rde, 0, 0, rr);
  endtask

  initial begin
    bit rr;
    bit pend;
    logic [7:0] pdata;
    int rd_pct;

    resetn = 1'b0; rx_valid = 1'b0; rx_data = '0; rd_en = 1'b0;
    clr_overflow = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    step(0, 0, 8'h00, 0, 0, 0, rr);
    chk("reset_level", 32'(level), 0);
    chk("reset_valid", 32'(rd_valid), 0);
    chk("reset_hold",  32'(rx_hold), 0);
    chk("reset_ovf",   32'(overflow), 0);

    // Three bytes offered one at a time.
    offer(8'h41, 0); chk("lvl1", 32'(level), 1);
    offer(8'h42, 0); chk("lvl2", 32'(level), 2);
    offer(8'h43, 0); chk("lvl3", 32'(level), 3);
    chk("head41", 32'(rd_data), 32'h41);
    chk("valid3", 32'(rd_valid), 1);

    // Pop all three, then one pop while empty, which must be ignored.
    for (int i = 0; i < 3; i++) begin
      #3 chk("pop_data", 32'(rd_data), 32'h41 + i);
      idle(1);
    end
    chk("empty_data", 32'(rd_data), 0);
    chk("empty_valid", 32'(rd_valid), 0);
    idle(1);
    chk("empty_rden_lvl", 32'(level), 0);

    // Fill to full. rx_hold rises with level 6. The pointers wrap.
    for (int i = 0; i < 8; i++) begin
      offer(8'(i), 0);
      chk("afull", 32'(rx_hold), 32'(i + 1 >= 6));
    end
    chk("full_lvl", 32'(level), 8);
    offer(8'h08, 0);
    chk("drop_ovf", 32'(overflow), 1);
    chk("drop_lvl", 32'(level), 8);
    for (int i = 0; i < 8; i++) begin
      #3 chk("wrap_data", 32'(rd_data), 32'(i));
      idle(1);
    end

    // Full FIFO with a simultaneous push and pop.
    for (int i = 0; i < 8; i++) offer(8'h10 + 8'(i), 0);
    offer(8'hAA, 1);
    chk("pp_lvl", 32'(level), 8);
    chk("pp_ovf", 32'(overflow), 1);
    for (int i = 0; i < 7; i++) idle(1);
    #3 chk("pp_last", 32'(rd_data), 32'hAA);
    idle(1);

    // A drop in the same cycle as clr_overflow keeps overflow set.
    for (int i = 0; i < 8; i++) offer(8'h20 + 8'(i), 0);
    step(1, 1, 8'h55, 0, 1, 0, rr);
    chk("clr_vs_set", 32'(overflow), 1);
    step(1, 0, 8'h00, 0, 1, 0, rr);
    chk("clr_alone", 32'(overflow), 0);

    // Flush at level 5 while the receiver holds a byte.
    repeat (3) idle(1);
    chk("pre_flush_lvl", 32'(level), 5);
    step(1, 1, 8'h77, 0, 0, 1, rr);
    chk("flush_rr", 32'(rr), 0);
    chk("flush_lvl", 32'(level), 0);
    offer(8'h77, 0);
    chk("post_flush_lvl", 32'(level), 1);
    chk("post_flush_data", 32'(rd_data), 32'h77);

    // Reset in the middle of a stream.
    offer(8'h01, 0); offer(8'h02, 0);
    for (int i = 0; i < 7; i++) offer(8'h03, 0);
    step(0, 0, 8'h00, 1, 0, 0, rr);
    chk("mid_rst_lvl",  32'(level), 0);
    chk("mid_rst_ovf",  32'(overflow), 0);
    chk("mid_rst_hold", 32'(rx_hold), 0);
    chk("mid_rst_data", 32'(rd_data), 0);

    // Random traffic. Fill-heavy and drain-heavy phases alternate.
    pend = 1'b0;
    pdata = 8'h00;
    rd_pct = 20;
    for (int c = 0; c < 3000; c++) begin
      bit rst, fl, clr, rde;
      if (c % 300 == 0) rd_pct = (rd_pct == 20) ? 80 : 20;
      if (!pend && $urandom_range(0, 99) < 60) begin
        pend  = 1'b1;
        pdata = 8'($urandom);
      end
      rst = ($urandom_range(0, 499) == 0);
      fl  = ($urandom_range(0, 59) == 0);
      clr = ($urandom_range(0, 19) == 0);
      rde = ($urandom_range(0, 99) < rd_pct);
      step(!rst, pend && !rst, pdata, rde, clr, fl, rr);
      if (rr) pend = 1'b0;
    end
    idle(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
